// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with whole-scan debounce, ghost lockout and press/release pulses.
// Optional auto-repeat of key_press is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       key_press,
  output logic       key_release,
  output logic       multi
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  if ((SCAN_DIV < 4) || (DEBOUNCE_SCANS < 1) || (REPEAT_SCANS < 1)) begin : g_param_check
    $error("keypad_scan_ctrl: unsupported parameter values");
  end

  typedef enum logic {IDLE, SCAN} state_t;
  typedef enum logic [1:0] {C_NONE, C_SINGLE, C_MULTI} cand_t;

  state_t          state, state_nxt;
  logic [1:0]      col_idx;
  logic [DW-1:0]   dwell;
  logic [11:0]     raw;
  cand_t           prev_kind;
  logic [3:0]      prev_code;
  logic [SW-1:0]   stable;

  logic [15:0]     scan_bits;
  logic [4:0]      ones;
  logic [3:0]      last_idx;
  cand_t           cand_kind;
  logic [3:0]      cand_code;
  logic [SW-1:0]   stable_nxt;
  logic            settled;
  logic            do_press;
  logic            do_release;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0]   rpt_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = SCAN;
      SCAN:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign col = (state == SCAN) ? ~(4'b0001 << col_idx) : 4'b1111;

  // Candidate for the scan ending now: column 3 comes straight off the pins.
  always_comb begin
    scan_bits = {~row, raw};
    ones      = '0;
    last_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_bits[i]) begin
        ones     = ones + 5'd1;
        last_idx = 4'(i);
      end
    end
    cand_kind  = (ones == 5'd0) ? C_NONE : ((ones == 5'd1) ? C_SINGLE : C_MULTI);
    cand_code  = (cand_kind == C_SINGLE) ? last_idx : 4'd0;
    if ((cand_kind == prev_kind) && (cand_code == prev_code))
      stable_nxt = (stable == SW'(DEBOUNCE_SCANS)) ? stable : stable + SW'(1);
    else
      stable_nxt = SW'(1);
    settled    = (stable_nxt == SW'(DEBOUNCE_SCANS));
    do_press   = settled && (cand_kind == C_SINGLE) && (!key_down || (key_code != cand_code));
    do_release = settled && (cand_kind == C_NONE) && key_down;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_idx     <= '0;
      dwell       <= '0;
      raw         <= '0;
      prev_kind   <= C_NONE;
      prev_code   <= '0;
      stable      <= '0;
      key_code    <= '0;
      key_down    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt     <= '0;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            col_idx <= '0;
            dwell   <= '0;
          end
        end
        SCAN: begin
          if (!en) begin
            col_idx   <= '0;
            dwell     <= '0;
            raw       <= '0;
            prev_kind <= C_NONE;
            prev_code <= '0;
            stable    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
            if (key_down) begin
              key_down    <= 1'b0;
              key_release <= 1'b1;
            end
          end else if (dwell == LAST) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            case (col_idx)
              2'd0: raw[3:0]  <= ~row;
              2'd1: raw[7:4]  <= ~row;
              2'd2: raw[11:8] <= ~row;
              default: begin
                multi     <= (cand_kind == C_MULTI);
                prev_kind <= cand_kind;
                prev_code <= cand_code;
                stable    <= stable_nxt;
                if (do_press) begin
                  key_code  <= cand_code;
                  key_down  <= 1'b1;
                  key_press <= 1'b1;
                end
                if (do_release) begin
                  key_down    <= 1'b0;
                  key_release <= 1'b1;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (do_press || do_release) begin
                  rpt_cnt <= '0;
                end else if (key_down && (cand_kind == C_SINGLE) && (cand_code == key_code)) begin
                  if (rpt_cnt == RW'(REPEAT_SCANS - 1)) begin
                    rpt_cnt   <= '0;
                    key_press <= 1'b1;
                  end else begin
                    rpt_cnt <= rpt_cnt + RW'(1);
                  end
                end else begin
                  rpt_cnt <= '0;
                end
`endif
              end
            endcase
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, per-scan reference model of debounce/commit.
// Directed scenarios followed by randomized key patterns, default build (no auto-repeat).
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int PERIOD = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_down;
  logic        key_press;
  logic        key_release;
  logic        multi;

  logic [15:0] pressed;

  int errors = 0;
  int checks = 0;

  int          hist[$];
  logic        exp_down;
  logic [3:0]  exp_code;
  logic        exp_multi;
  logic        exp_press;
  logic        exp_rel;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(8)) dut (
    .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
    .key_code(key_code), .key_down(key_down), .key_press(key_press),
    .key_release(key_release), .multi(multi)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Diode-isolated keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (pressed[4*c+r]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a full scan with this mask should do to the committed key.
  task automatic model_eval(input logic [15:0] mask);
    int n;
    int cand;
    bit same;
    n = $countones(mask);
    cand = -1;
    if (n > 1) cand = 16;
    else if (n == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) cand = i;
    hist.push_back(cand);
    if (hist.size() > DB) void'(hist.pop_front());
    exp_multi = (n > 1);
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    if (hist.size() == DB && cand != 16) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != cand) same = 1'b0;
      if (same) begin
        if (cand == -1 && exp_down) begin
          exp_down = 1'b0;
          exp_rel  = 1'b1;
        end else if (cand >= 0 && (!exp_down || exp_code != 4'(cand))) begin
          exp_down  = 1'b1;
          exp_code  = 4'(cand);
          exp_press = 1'b1;
        end
      end
    end
  endtask

  // Entered at cycle 0 of a scan (col=1110); returns at cycle 0 of the next scan.
  task automatic do_scan(input logic [15:0] mask);
    logic [3:0] exp_col;
    pressed = mask;
    for (int t = 0; t < PERIOD; t++) begin
      exp_col = 4'b1111 ^ (4'b0001 << (t / SD));
      check("col_seq", {12'd0, col}, {12'd0, exp_col});
      if (t > 0) check("no_mid_pulse", {14'd0, key_press, key_release}, 16'd0);
      @(posedge clk); #1;
    end
    model_eval(mask);
    check("key_press", {15'd0, key_press}, {15'd0, exp_press});
    check("key_release", {15'd0, key_release}, {15'd0, exp_rel});
    check("key_down", {15'd0, key_down}, {15'd0, exp_down});
    check("key_code", {12'd0, key_code}, {12'd0, exp_code});
    check("multi", {15'd0, multi}, {15'd0, exp_multi});
  endtask

  initial begin
    int w;
    logic [15:0] mask;
    int k1;
    int k2;
    int mode;
    int hold;

    rst = 1'b0;
    en = 1'b1;
    pressed = '0;
    exp_down = 1'b0;
    exp_code = '0;
    exp_multi = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_col", {12'd0, col}, 16'h000f);
    check("reset_outs", {8'd0, key_code, key_down, key_press, key_release, multi}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    w = 0;
    while (col !== 4'b1110 && w < 8) begin
      check("idle_outs", {8'd0, key_code, key_down, key_press, key_release, multi}, 16'd0);
      @(posedge clk); #1;
      w++;
    end
    check("scan_start", {12'd0, col}, 16'h000e);

    // idle keypad, then key 6 press and hold
    repeat (3) do_scan(16'h0000);
    repeat (4) do_scan(16'h0040);
    // release
    repeat (3) do_scan(16'h0000);
    // bounce: key on alternate scans
    for (int i = 0; i < 10; i++) do_scan((i % 2 == 0) ? 16'h0040 : 16'h0000);
    // ghosting pair 6+9, then 9 released
    repeat (3) do_scan(16'h0240);
    repeat (3) do_scan(16'h0040);

    // drop en mid-column while key 6 is committed
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
    end
    en = 1'b0;
    @(posedge clk); #1;
    check("dis_col", {12'd0, col}, 16'h000f);
    check("dis_down", {15'd0, key_down}, 16'd0);
    check("dis_release", {15'd0, key_release}, 16'd1);
    check("dis_press", {15'd0, key_press}, 16'd0);
    check("dis_code", {12'd0, key_code}, 16'd6);
    exp_down = 1'b0;
    hist.delete();
    @(posedge clk); #1;
    check("dis_pulse_end", {15'd0, key_release}, 16'd0);
    check("idle_col", {12'd0, col}, 16'h000f);
    en = 1'b1;
    @(posedge clk); #1;
    check("reen_col", {12'd0, col}, 16'h000e);
    repeat (3) do_scan(16'h0040);

    // randomized key patterns held for a few scans each
    mask = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      k1 = $urandom_range(0, 15);
      k2 = (k1 + $urandom_range(1, 15)) % 16;
      case (mode)
        0: mask = 16'h0000;
        1: mask = 16'h0001 << k1;
        2: mask = (16'h0001 << k1) | (16'h0001 << k2);
        default: ;
      endcase
      repeat (hold) do_scan(mask);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad that feeds the keyboard audio path. It drives one column low at a time and samples the active-low rows. Each full scan is debounced, and the controller emits a key code with press/release pulses. The audio/tone logic consumes `key_code`, `key_down` and the pulses instead of reading raw row/col.

Parameters:
- SCAN_DIV, 100000: clock cycles each column is driven (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to commit a change; minimum 1.
- REPEAT_SCANS, 64: auto-repeat interval in full scans; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: scan enable.
- row, input, 4: keypad rows, active-low, externally pulled up.
- col, output, 4: keypad columns, one-cold drive; 4'b1111 means no column driven.
- key_code, output, 4: committed key index = 4*col_idx + row_idx.
- key_down, output, 1: a single committed key is held.
- key_press, output, 1: one-cycle pulse when a key is committed.
- key_release, output, 1: one-cycle pulse when a committed key is released.
- multi, output, 1: last full scan saw more than one key.

Behaviour:
- Reset (rst=0, asynchronous): `col`=4'b1111. `key_code`, `key_down`, `key_press`, `key_release` and `multi` = 0. All counters, raw map and debounce state cleared.
- FSM states: IDLE, SCAN.
  - IDLE: `col`=4'b1111. Moves to SCAN when en=1, with col_idx=0 and dwell=0.
  - SCAN: `col` = ~(4'b0001 << col_idx). `dwell` counts 0..SCAN_DIV-1.
- Sampling: rows are sampled at dwell==SCAN_DIV-1; the first SCAN_DIV-1 cycles are settle time. raw[4*col_idx+r] = ~row[r]. col_idx then advances, wrapping 3 -> 0.
- Scan period: exactly 4*SCAN_DIV cycles. Evaluation happens on the column-3 sample edge, using the current row merged with raw bits 0..11.
- Candidate per scan: NONE if no bit is set; SINGLE(k) if exactly one bit k is set; MULTI otherwise. `multi` is registered at each evaluation.
- Debounce:
  - If the candidate equals the previous scan's candidate, `stable` increments, saturating at DEBOUNCE_SCANS; otherwise `stable`=1.
  - A commit occurs when stable==DEBOUNCE_SCANS and the candidate differs from the committed state.
- Commit rules:
  - NONE -> SINGLE(k): `key_code`=k, `key_down`=1, `key_press` pulses.
  - SINGLE -> NONE: `key_down`=0, `key_release` pulses, `key_code` holds its last value.
  - SINGLE(a) -> SINGLE(b): `key_code`=b and `key_press` pulses only; no release pulse.
  - MULTI never commits; the committed state is held, which locks out ghosting.
- Pulses last exactly one clk cycle, coincident with the `key_code`/`key_down` update.
- en deassert mid-scan: next cycle the FSM enters IDLE, `col`=4'b1111 and scan/debounce state is cleared.
  - If `key_down` was 1: `key_down`->0 and `key_release` pulses on that same cycle.
- en reassert: a fresh scan starts at col_idx 0.
- Press latency from a clean press: commit at the end of the DEBOUNCE_SCANS-th full scan that sees the key.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: while `key_down`=1 and the candidate remains SINGLE(`key_code`), `key_press` re-pulses every REPEAT_SCANS evaluations after the initial commit. The repeat counter resets on any commit or on release.
- Undefined: exactly one `key_press` per commit; no repeat counter is synthesised.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan period 16 cycles):
1. Reset and scan: rst=0 then rst=1, en=1, row=4'b1111 -> `col`=1111 during reset. Afterwards `col` sequences 1110, 1101, 1011, 0111, 4 cycles each, repeating. All key outputs stay 0.
2. Press: drive row[2]=0 only while col=1101, held -> after 2 full scans a single `key_press` pulse, `key_code`=6, `key_down`=1. No further pulses while held (macro off).
3. Release: hold the key from scenario 2, then restore row=1111 -> after 2 scans a `key_release` pulse, `key_down`=0, `key_code` remains 6.
4. Bounce: key 6 present on alternate scans for 10 scans -> no `key_press`, `key_down` stays 0.
5. Ghost/multi: keys 6 and 9 held together -> `multi`=1 at each evaluation, no pulses. Release key 9 -> commit of 6 after 2 scans.
6. Disable: hold key 6 committed, drop en mid-column -> next cycle `col`=1111, `key_down`=0, one `key_release` pulse. Reassert en -> scan restarts at `col`=1110.
